// File: rtl/spram_pkg.sv
// ---------------------------------------------------------------------------
// spram_pkg
// Shared constants and types for the spram single-port RAM wrapper and the
// ring-buffer FIFO controller that sequences it.
//   WIDTH   : data word width (must match the spram wrapper)
//   DEPTH   : RAM entries (power of two, so pointers wrap for free)
//   ADDRW   : RAM address width
//   WE_ALL / WE_NONE : nibble write-enable masks for a full-word write / idle
//   spram_ctl_state_t : controller FSM states
// ---------------------------------------------------------------------------
package spram_pkg;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16384;
  localparam int ADDRW = $clog2(DEPTH);

  localparam logic [3:0] WE_ALL  = 4'hF;
  localparam logic [3:0] WE_NONE = 4'h0;

  typedef enum logic {
    S_IDLE,
    S_RD_WAIT
  } spram_ctl_state_t;

endpackage

// File: rtl/spram_fifo_ctrl_if.sv
// ---------------------------------------------------------------------------
// spram_fifo_ctrl_if
// Bundles the FIFO write port, FIFO read port, fill level and the RAM-side
// bus of the spram FIFO controller.
//   wr_valid/wr_ready/wr_data : producer handshake into the FIFO
//   rd_valid/rd_ready/rd_data : consumer handshake out of the FIFO
//   fill                      : words held (RAM + in-flight read + output reg)
//   ram_we/ram_addr/ram_din   : controller -> spram
//   ram_dout                  : spram -> controller (one cycle after address)
// Modports:
//   slave  : the controller side
//   master : the surrounding system (producer, consumer and RAM)
// ---------------------------------------------------------------------------
interface spram_fifo_ctrl_if;
  import spram_pkg::*;

  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data;

  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;

  logic [ADDRW:0]   fill;

  logic [3:0]       ram_we;
  logic [ADDRW-1:0] ram_addr;
  logic [WIDTH-1:0] ram_din;
  logic [WIDTH-1:0] ram_dout;

  modport slave (
    input  wr_valid, wr_data, rd_ready, ram_dout,
    output wr_ready, rd_valid, rd_data, fill, ram_we, ram_addr, ram_din
  );

  modport master (
    output wr_valid, wr_data, rd_ready, ram_dout,
    input  wr_ready, rd_valid, rd_data, fill, ram_we, ram_addr, ram_din
  );

endinterface

// File: rtl/spram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// spram_fifo_ctrl
// Turns the spram single-port RAM (registered read data) into a ring-buffer
// FIFO. Words accepted on the write port are returned in order on the read
// port. Only one RAM access happens per cycle; a read issue has priority
// over a write. A read issued in cycle N lands in the output register at the
// end of cycle N+1 and is presented on rd_valid/rd_data in cycle N+2.
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset (RAM contents are kept)
//   bus  : spram_fifo_ctrl_if.slave - write/read handshakes, fill, RAM bus
// ---------------------------------------------------------------------------
module spram_fifo_ctrl
  import spram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  spram_fifo_ctrl_if.slave  bus
);

  localparam logic [ADDRW:0]   CNT_FULL = (ADDRW+1)'(DEPTH);
  localparam logic [ADDRW-1:0] PTR_ONE  = ADDRW'(1);
  localparam logic [ADDRW:0]   CNT_ONE  = (ADDRW+1)'(1);

  spram_ctl_state_t state_q, state_d;

  logic [ADDRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDRW-1:0] ram_addr_q, ram_addr_d;
  logic [ADDRW:0]   ram_cnt_q, ram_cnt_d;
  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] out_reg_q, out_reg_d;

  logic space_next;
  logic rd_go;
  logic wr_go;
  logic wr_ready;
  logic capture;
  logic pop;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: S_RD_WAIT always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (rd_go) state_d = S_RD_WAIT;
      S_RD_WAIT: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs and port arbitration. A read is only issued when the output
  // register is guaranteed free at the capture edge, so the capture in
  // S_RD_WAIT never overwrites an unconsumed word. Writes yield the port to
  // a read issue.
  always_comb begin
    space_next = !out_vld_q || bus.rd_ready;
    rd_go      = 1'b0;
    capture    = 1'b0;
    case (state_q)
      S_IDLE:    rd_go   = !rst && (ram_cnt_q != '0) && space_next;
      S_RD_WAIT: capture = 1'b1;
      default:   ;
    endcase
    wr_ready = !rst && (ram_cnt_q != CNT_FULL) && !rd_go;
    wr_go    = bus.wr_valid && wr_ready;
    pop      = out_vld_q && bus.rd_ready;
  end

  // Datapath next state. rd_go and wr_go are mutually exclusive, so ram_cnt
  // only ever moves by one. ram_addr holds its last value on idle cycles.
  // A capture coinciding with a pop replaces the word and keeps it valid.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    ram_addr_d = ram_addr_q;
    out_vld_d  = out_vld_q;
    out_reg_d  = out_reg_q;

    if (rd_go) begin
      ram_addr_d = rd_ptr_q;
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      ram_cnt_d  = ram_cnt_q - CNT_ONE;
    end else if (wr_go) begin
      ram_addr_d = wr_ptr_q;
      wr_ptr_d   = wr_ptr_q + PTR_ONE;
      ram_cnt_d  = ram_cnt_q + CNT_ONE;
    end

    if (capture) begin
      out_reg_d = bus.ram_dout;
      out_vld_d = 1'b1;
    end else if (pop) begin
      out_vld_d = 1'b0;
    end
  end

  // Control registers; reset drops any in-flight read via state and out_vld.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      ram_addr_q <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      ram_addr_q <= ram_addr_d;
      out_vld_q  <= out_vld_d;
    end
  end

  // Output data register needs no reset: it is qualified by out_vld.
  always_ff @(posedge clk) begin
    out_reg_q <= out_reg_d;
  end

  assign bus.wr_ready = wr_ready;
  assign bus.rd_valid = out_vld_q;
  assign bus.rd_data  = out_reg_q;
  assign bus.ram_we   = wr_go ? WE_ALL : WE_NONE;
  assign bus.ram_addr = ram_addr_d;
  assign bus.ram_din  = bus.wr_data;

  // Fill counts the word travelling from RAM to the output register too,
  // so it can reach DEPTH+1.
  assign bus.fill = ram_cnt_q
                  + (ADDRW+1)'(state_q == S_RD_WAIT)
                  + (ADDRW+1)'(out_vld_q);

  a_no_double_access: assert property (@(posedge clk) disable iff (rst)
    !(wr_go && rd_go));

  a_cnt_in_range: assert property (@(posedge clk)
    ram_cnt_q <= CNT_FULL);

  a_rd_data_stable: assert property (@(posedge clk) disable iff (rst)
    (out_vld_q && !bus.rd_ready) |=> (out_vld_q && $stable(out_reg_q)));

endmodule

// File: doc/spram_fifo_ctrl.md
Name: spram_fifo_ctrl

Overview:
- Sequencing controller that sits directly upstream of the spram single-port RAM wrapper (16-bit x 16384, registered read data) and turns it into a ring-buffer FIFO.
- Accepts 16-bit words on a valid/ready write port and returns them in order on a valid/ready read port.
- Drives the RAM's write-enable nibble mask, address and write data, and consumes its read data.
- Arbitrates the single RAM port: at most one RAM access per cycle.

Parameters:
- WIDTH, 16, data word width; must match the spram wrapper.
- DEPTH, 16384, RAM entries; power of two.
- ADDRW, $clog2(DEPTH), RAM address width (14).

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  reset; synchronous, active-high.
- wr_valid  input  1  write word offered.
- wr_ready  output  1  controller accepts the write word this cycle.
- wr_data  input  WIDTH  write word.
- rd_valid  output  1  output word available.
- rd_ready  input  1  consumer takes the output word this cycle.
- rd_data  output  WIDTH  output word, held stable while rd_valid=1 and rd_ready=0.
- fill  output  ADDRW+1  total words held: RAM, plus in-flight read, plus output register.
- ram_we  output  4  nibble write mask to spram; 4'hF on a write, 4'h0 otherwise.
- ram_addr  output  ADDRW  spram address.
- ram_din  output  WIDTH  spram write data (equals wr_data on a write cycle).
- ram_dout  input  WIDTH  spram read data, valid the cycle after its address is presented.

Behaviour:
- State: wr_ptr, rd_ptr (ADDRW bits, wrap DEPTH-1 -> 0), ram_cnt (0..DEPTH), out_vld, out_reg, FSM {S_IDLE, S_RD_WAIT}.
- Reset, on a rising edge while rst=1:
  - pointers, ram_cnt and out_vld are cleared; state goes to S_IDLE.
  - rd_valid=0, wr_ready=0 while rst=1, ram_we=0, fill=0.
  - An in-flight read is discarded. RAM contents are not cleared.
- space_next = !out_vld || rd_ready (the output register is free at the next edge).
- Read issue (rd_go) requires all of: state==S_IDLE, ram_cnt!=0, space_next.
  - Drives ram_addr=rd_ptr and ram_we=0.
  - At the edge: rd_ptr+1, ram_cnt-1, state goes to S_RD_WAIT.
- Write (wr_go): wr_ready = !rst && ram_cnt!=DEPTH && !rd_go; wr_go = wr_valid && wr_ready.
  - Drives ram_addr=wr_ptr, ram_we=4'hF, ram_din=wr_data.
  - At the edge: wr_ptr+1, ram_cnt+1.
- Priority: a read issue beats a write in the same cycle. There are never two RAM accesses in one cycle.
- S_RD_WAIT (exactly one cycle):
  - out_reg<=ram_dout and out_vld<=1 at the edge; then return to S_IDLE.
  - A write may be issued in this cycle. A read may not.
- Output handshake:
  - rd_valid=out_vld.
  - If rd_ready && out_vld and no capture occurs, out_vld<=0.
  - A capture in the same cycle as a pop replaces the word and keeps out_vld=1.
- Latency: a read issued in cycle N puts the word on rd_valid/rd_data in cycle N+2. Sustained streaming gives 1 word per 2 cycles.
- Word written in cycle N: the earliest read issue is cycle N+1 (ram_cnt updated at the edge), so the earliest rd_valid is N+3.
- Full: ram_cnt==DEPTH drops wr_ready. The output register adds one extra word, so fill can reach DEPTH+1; fill width must cover this.
- Empty: ram_cnt==0 means no read issue. rd_valid stays 0 once the output register drains.
- Simultaneous wr_go and rd_ready pop: both take effect, and fill is unchanged.
- ram_cnt updates: +1 on wr_go, -1 on rd_go. The two never coincide.
- Idle bus: ram_addr holds its last value and ram_we=0.
- Assertions:
  - never wr_go && rd_go;
  - ram_cnt <= DEPTH;
  - rd_data stable under backpressure.

Decomposition:
- Shared package spram_pkg holds:
  - WIDTH=16, DEPTH=16384, ADDRW=14;
  - WE_ALL=4'hF, WE_NONE=4'h0;
  - typedef enum logic {S_IDLE, S_RD_WAIT} spram_ctl_state_t.
- No sub-module: the controller is one flat module. It is instantiated beside spram at the top level, with ram_* wired to we/addr/data_in/data_out.
- The bench uses a behavioural 1-cycle-latency RAM model.

Test Plan:
1. Reset then idle. Response: wr_ready=1, rd_valid=0, fill=0, ram_we=0. Assert rst mid-stream with fill=5: next cycle fill=0, rd_valid=0, the stale read is discarded, and old data never appears.
2. Write 0x1234, 0xABCD with rd_ready=1. Response: ram_we=4'hF at addr 0 then addr 1; rd_data 0x1234 then 0xABCD in order; first rd_valid 3 cycles after the first wr_go.
3. Fill 16384 words plus one more (rd_ready=0). Response: the first is read into out_reg; wr_ready drops once ram_cnt=16384; fill=16385; wr_valid held high is not accepted.
4. Wrap: stream 20000 incrementing words with random rd_ready. Response: output equals input order, and ram_addr wraps 16383 -> 0 for both pointers.
5. Conflict: wr_valid=1 continuously, with ram_cnt>0 and the output empty. Response: wr_ready=0 in the rd_go cycle; reads and writes never coincide; throughput is 1 read and 1 write per 2 cycles.
6. Backpressure: rd_ready=0 for 10 cycles with rd_valid=1. Response: rd_data is held, and no further reads issue while out_vld=1 and rd_ready=0.
